fir_cfg_sequencer: RTL and testbench
====================================

// Module: fir_cfg_sequencer
// PURPOSE
// - Host-side config write sequencer in clk_a domain, directly upstream of the clk_a->clk_b CDC handshake stage.
// - Queues host register writes (6-bit address, 16-bit data) for the FIR core and issues them one at a time as single-cycle p_wr pulses.
// - Enforces a fixed hold-off so each 4-phase req/ack round trip fully completes before the next issue.
// - Captures p_data_back after each transaction and returns it to the host.
// PARAMETERS
// - DEPTH       8   command FIFO entries; power of 2, >=2
// - GAP_CYCLES  16  clk_a cycles from p_wr pulse to read-back capture; must exceed full 4-phase round trip (2 clk_b + 1 clk_b + 2 clk_a each way), >=4
// - AW          6   address width
// - DW          16  data width
// PORTS
// - clk_a        in   1              clock, domain A
// - rst_n        in   1              reset: asynchronous, active-low
// - host_valid   in   1              host write request
// - host_ready   out  1              = !fifo_full; transfer occurs when host_valid && host_ready
// - host_addr    in   AW             target register address
// - host_data    in   DW             write data
// - p_address    out  AW             address to CDC, held stable ISSUE..CAPTURE
// - p_data       out  DW             data to CDC, held stable ISSUE..CAPTURE
// - p_wr         out  1              single-cycle issue strobe to CDC
// - p_data_back  in   DW             read-back from CDC
// - rd_valid     out  1              1-cycle pulse: rd_addr/rd_data valid
// - rd_addr      out  AW             address of completed transaction
// - rd_data      out  DW             captured p_data_back
// - busy         out  1              FSM not IDLE or FIFO non-empty
// - fifo_level   out  $clog2(DEPTH+1) current FIFO occupancy
// BEHAVIOUR
// - Reset: all outputs 0 except host_ready=1; FIFO empty; FSM=IDLE; counter=0. Mid-operation reset discards queue and in-flight transaction; p_wr drops immediately.
// - FIFO: synchronous, registered output, no fall-through. A push to an empty FIFO is poppable the next cycle at earliest.
// - Push when full: host_ready=0, no transfer, no state change. Push and pop in the same cycle: level unchanged. Pointers wrap modulo DEPTH.
// - FSM IDLE: if level!=0, pop head into p_address/p_data -> ISSUE.
// - FSM ISSUE: p_wr=1 for exactly this cycle; counter<=GAP_CYCLES-2 -> WAIT.
// - FSM WAIT: counter decrements each cycle; at 0 -> CAPTURE.
// - FSM CAPTURE: rd_data<=p_data_back, rd_addr<=p_address, rd_valid=1 next cycle (1 cycle) -> IDLE.
// - Issue spacing: p_wr pulses are >= GAP_CYCLES+2 clk_a cycles apart. p_wr is never reasserted while the CDC could still be mid-handshake.
// - Back-to-back FIFO contents drain with no extra idle cycles beyond IDLE->ISSUE.
// - rd_valid has no backpressure; the host must accept it.
// CONFIGURATION
// - Macro FIR_CFG_SEQ_STATS_EN defined: adds output tx_count[15:0].
//   - Increments by 1 on each CAPTURE, saturates at 16'hFFFF, reset to 0.
//   - Adds output stall_seen[0:0]: sticky flag, set when host_valid && !host_ready, cleared only by reset.
// - Macro undefined: these ports and logic are absent. All other behaviour is identical.
// STRUCTURE
// - Package fir_cfg_pkg: AW/DW localparams, typedef enum logic[1:0] {IDLE,ISSUE,WAIT,CAPTURE} seq_state_t, typedef struct packed {addr,data} cfg_cmd_t, default GAP_CYCLES.
// - Sub-module fir_cfg_fifo: parameterised sync FIFO of cfg_cmd_t (DEPTH, push/pop/full/empty/level).
// - Top: FSM, gap counter, read-back capture, optional stats.
// TESTING
// - Single write {addr=6'h05,data=16'hA5A5}:
//   - p_wr high exactly 1 cycle, 2 cycles after the accept, with p_address=5 and p_data=A5A5.
//   - rd_valid at +GAP_CYCLES+1 after p_wr, carrying the p_data_back value driven by the bench.
// - Burst of 8 writes (addr 0..7) back-to-back:
//   - host_ready never drops (DEPTH=8).
//   - p_wr pulses spaced exactly GAP_CYCLES+2; rd_addr sequence 0..7 in order.
// - Burst of 12 writes:
//   - host_ready=0 once level=8; accepted count equals issued count; no loss, no duplicates.
//   - FIR_CFG_SEQ_STATS_EN: stall_seen=1, tx_count=12.
// - Bench CDC model (clk_b 3x slower):
//   - Every transaction completes, and p_wr never occurs while the model's req or ack is high.
// - rst_n asserted during WAIT with 3 entries queued:
//   - Outputs return to reset values asynchronously; after release, zero p_wr pulses occur.
// - Push in the same cycle as a pop at level=1:
//   - Level stays 1; the second entry issues next in order.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// rtl/fir_cfg_pkg.sv - shared types and widths for the FIR config write sequencer
package fir_cfg_pkg;

    localparam int AW             = 6;
    localparam int DW             = 16;
    localparam int GAP_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cfg_cmd_t;

endpackage

// File: rtl/fir_cfg_fifo.sv
// rtl/fir_cfg_fifo.sv - synchronous command FIFO of cfg_cmd_t, power-of-2 depth
module fir_cfg_fifo
    import fir_cfg_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_a,
    input  logic          rst_n,
    input  logic          push,
    input  cfg_cmd_t      push_cmd,
    input  logic          pop,
    output cfg_cmd_t      head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    cfg_cmd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Flags come from the registered level, so a fresh entry is never visible
    // in the cycle it is written.
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_a) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_cfg_sequencer.sv
// rtl/fir_cfg_sequencer.sv - queues host config writes and issues them to the clk_a->clk_b CDC with a fixed hold-off; optional FIR_CFG_SEQ_STATS_EN adds tx_count/stall_seen
module fir_cfg_sequencer
    import fir_cfg_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int GAP_CYCLES = GAP_CYCLES_DEF,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic          clk_a,
    input  logic          rst_n,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic [AW-1:0] p_address,
    output logic [DW-1:0] p_data,
    output logic          p_wr,
    input  logic [DW-1:0] p_data_back,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic [LW-1:0] fifo_level
`ifdef FIR_CFG_SEQ_STATS_EN
    ,
    output logic [15:0]   tx_count,
    output logic [0:0]    stall_seen
`endif
);

    localparam int CW = $clog2(GAP_CYCLES);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [CW-1:0] gap_cnt;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    cfg_cmd_t      push_cmd;
    cfg_cmd_t      head_cmd;

    assign push_cmd.addr = host_addr;
    assign push_cmd.data = host_data;
    assign host_ready    = !fifo_full;
    assign busy          = (state_q != IDLE) || !fifo_empty;

    fir_cfg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_a    (clk_a),
        .rst_n    (rst_n),
        .push     (host_valid),
        .push_cmd (push_cmd),
        .pop      (fifo_pop),
        .head     (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (gap_cnt == '0) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // p_wr is registered off the next state so the CDC sees a clean one-cycle
    // strobe aligned with ISSUE, and the async reset kills it immediately.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt   <= '0;
            p_address <= '0;
            p_data    <= '0;
            p_wr      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else begin
            p_wr     <= (state_d == ISSUE);
            rd_valid <= (state_q == CAPTURE);
            if (fifo_pop) begin
                p_address <= head_cmd.addr;
                p_data    <= head_cmd.data;
            end
            if (state_q == ISSUE) begin
                gap_cnt <= CW'(GAP_CYCLES - 2);
            end else if ((state_q == WAIT) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - CW'(1);
            end
            if (state_q == CAPTURE) begin
                rd_addr <= p_address;
                rd_data <= p_data_back;
            end
        end
    end

`ifdef FIR_CFG_SEQ_STATS_EN
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            tx_count   <= '0;
            stall_seen <= 1'b0;
        end else begin
            if ((state_q == CAPTURE) && (tx_count != 16'hFFFF)) begin
                tx_count <= tx_count + 16'd1;
            end
            if (host_valid && !host_ready) begin
                stall_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb/tb_fir_cfg_sequencer.sv - scoreboard bench for fir_cfg_sequencer with a 4-phase CDC model on a 3x slower clk_b
module tb_fir_cfg_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP   = 16;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk_a = 1'b0;
    logic        clk_b = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [5:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    logic [5:0]  p_address;
    logic [15:0] p_data;
    logic        p_wr;
    logic [15:0] p_data_back;
    logic        rd_valid;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic [3:0]  fifo_level;
`ifdef FIR_CFG_SEQ_STATS_EN
    logic [15:0] tx_count;
    logic [0:0]  stall_seen;
`endif

    fir_cfg_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_a       (clk_a),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .p_address   (p_address),
        .p_data      (p_data),
        .p_wr        (p_wr),
        .p_data_back (p_data_back),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .fifo_level  (fifo_level)
`ifdef FIR_CFG_SEQ_STATS_EN
        ,
        .tx_count    (tx_count),
        .stall_seen  (stall_seen)
`endif
    );

    always #5 clk_a = ~clk_a;
    initial begin
        #3;
        forever #15 clk_b = ~clk_b;
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    int   pw_q[$];
    int   rv_q[$];
    logic [5:0]  pa_q[$];
    logic [15:0] pd_q[$];
    int   n_issued  = 0;
    int   n_acc     = 0;
    int   stalls    = 0;
    int   max_level = 0;
    logic pwr_prev  = 1'b0;
    logic rv_prev   = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // CDC model: req in clk_a, two-flop sync to clk_b, ack back through two clk_a flops
    logic        m_req = 1'b0, m_as1 = 1'b0, m_as2 = 1'b0;
    logic        m_rs1 = 1'b0, m_ack = 1'b0;
    logic [5:0]  m_addr = '0, core_addr = '0;
    logic [15:0] m_data = '0, core_data = '0;
    int          m_done = 0;

    assign p_data_back = ~core_data;

    always @(posedge clk_a) begin
        cyc   <= cyc + 1;
        m_as1 <= m_ack;
        m_as2 <= m_as1;
        if (p_wr) begin
            m_req  <= 1'b1;
            m_addr <= p_address;
            m_data <= p_data;
        end else if (m_as2) begin
            m_req <= 1'b0;
        end
    end

    always @(posedge clk_b) begin
        m_rs1 <= m_req;
        m_ack <= m_rs1;
        if (m_rs1 && !m_ack) begin
            core_addr <= m_addr;
            core_data <= m_data;
            m_done    <= m_done + 1;
        end
    end

    always @(negedge clk_a) begin
        exp_t e;
        if (p_wr) begin
            chk_eq("p_wr_single_cycle", {31'b0, pwr_prev}, 32'd0);
            chk_eq("cdc_idle_at_issue", {31'b0, m_req | m_ack}, 32'd0);
            pw_q.push_back(cyc);
            pa_q.push_back(p_address);
            pd_q.push_back(p_data);
            n_issued++;
        end
        if (rd_valid) begin
            chk_eq("rd_valid_single_cycle", {31'b0, rv_prev}, 32'd0);
            rv_q.push_back(cyc);
            chk_eq("sb_has_entry", {31'b0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_eq("rd_addr", {26'b0, rd_addr}, {26'b0, e.addr});
                chk_eq("rd_data", {16'b0, rd_data}, {16'b0, e.data});
            end
        end
        if (!host_ready) begin
            chk_eq("full_level", {28'b0, fifo_level}, DEPTH);
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        pwr_prev = p_wr;
        rv_prev  = rd_valid;
    end

    task automatic send(input logic [5:0] a, input logic [15:0] d, output int acc);
        int n;
        exp_t e;
        n = 0;
        acc = -1;
        @(negedge clk_a);
        host_valid = 1'b1;
        host_addr  = a;
        host_data  = d;
        while (!host_ready && n < 500) begin
            stalls++;
            n++;
            @(negedge clk_a);
        end
        if (!host_ready) begin
            chk_eq("accept_timeout", n, 0);
        end else begin
            e.addr = a;
            e.data = ~d;
            sb_q.push_back(e);
            acc = cyc;
            n_acc++;
        end
    endtask

    task automatic bus_idle();
        @(negedge clk_a);
        host_valid = 1'b0;
    endtask

    task automatic wait_idle(input int extra);
        int n;
        n = 0;
        do begin
            @(negedge clk_a);
            n++;
        end while (busy && n < 2000);
        chk_eq("drain_busy", {31'b0, busy}, 32'd0);
        repeat (extra) @(negedge clk_a);
        chk_eq("sb_drained", sb_q.size(), 0);
    endtask

    task automatic clear_logs();
        pw_q.delete();
        rv_q.delete();
        pa_q.delete();
        pd_q.delete();
        stalls    = 0;
        max_level = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_p_wr"}, {31'b0, p_wr}, 32'd0);
        chk_eq({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
        chk_eq({tag, "_rd_addr"}, {26'b0, rd_addr}, 32'd0);
        chk_eq({tag, "_rd_data"}, {16'b0, rd_data}, 32'd0);
        chk_eq({tag, "_p_address"}, {26'b0, p_address}, 32'd0);
        chk_eq({tag, "_p_data"}, {16'b0, p_data}, 32'd0);
        chk_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk_eq({tag, "_level"}, {28'b0, fifo_level}, 32'd0);
        chk_eq({tag, "_host_ready"}, {31'b0, host_ready}, 32'd1);
`ifdef FIR_CFG_SEQ_STATS_EN
        chk_eq({tag, "_tx_count"}, {16'b0, tx_count}, 32'd0);
        chk_eq({tag, "_stall_seen"}, {31'b0, stall_seen}, 32'd0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, tmp, acc_before;

        repeat (3) @(negedge clk_a);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_a);

        // single write
        clear_logs();
        send(6'h05, 16'hA5A5, acc0);
        bus_idle();
        wait_idle(30);
        chk_eq("single_issue_count", pw_q.size(), 1);
        if (pw_q.size() == 1 && rv_q.size() == 1) begin
            chk_eq("single_issue_latency", pw_q[0] - acc0, 2);
            chk_eq("single_p_address", {26'b0, pa_q[0]}, 32'h05);
            chk_eq("single_p_data", {16'b0, pd_q[0]}, 32'hA5A5);
            chk_eq("single_rd_latency", rv_q[0] - pw_q[0], GAP + 1);
        end

        // push in the same cycle as the pop at level 1
        clear_logs();
        send(6'h01, 16'h1111, acc0);
        send(6'h02, 16'h2222, acc1);
        bus_idle();
        chk_eq("pushpop_level", {28'b0, fifo_level}, 32'd1);
        wait_idle(30);
        chk_eq("pushpop_issue_count", pw_q.size(), 2);
        if (pa_q.size() == 2) begin
            chk_eq("pushpop_order0", {26'b0, pa_q[0]}, 32'd1);
            chk_eq("pushpop_order1", {26'b0, pa_q[1]}, 32'd2);
        end

        // back-to-back burst that fits in the FIFO
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            send(6'(i), 16'($urandom), tmp);
        end
        bus_idle();
        wait_idle(30);
        chk_eq("b8_no_stall", stalls, 0);
        chk_eq("b8_issue_count", pw_q.size(), 8);
        for (int i = 0; i + 1 < pw_q.size(); i++) begin
            chk_eq("b8_spacing", pw_q[i+1] - pw_q[i], GAP + 2);
        end

        // reset in WAIT with three entries still queued
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            send(6'(8 + i), 16'($urandom), tmp);
        end
        bus_idle();
        chk_eq("rst_pre_level", {28'b0, fifo_level}, 32'd3);
        repeat (3) @(negedge clk_a);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb_q.delete();
        repeat (3) @(negedge clk_a);
        rst_n = 1'b1;
        clear_logs();
        repeat (60) @(negedge clk_a);
        chk_eq("midrst_no_issue", pw_q.size(), 0);
        chk_eq("midrst_no_rd_valid", rv_q.size(), 0);
        chk_eq("midrst_idle_busy", {31'b0, busy}, 32'd0);

        // overflowing burst
        clear_logs();
        acc_before = n_acc;
        for (int i = 0; i < 12; i++) begin
            send(6'(16 + i), 16'($urandom), tmp);
        end
        bus_idle();
        wait_idle(30);
        chk_eq("b12_stalled", {31'b0, stalls != 0}, 32'd1);
        chk_eq("b12_max_level", max_level, DEPTH);
        chk_eq("b12_accepted", n_acc - acc_before, 12);
        chk_eq("b12_issued", pw_q.size(), n_acc - acc_before);
        for (int i = 0; i < pa_q.size(); i++) begin
            chk_eq("b12_issue_order", {26'b0, pa_q[i]}, 16 + i);
        end
`ifdef FIR_CFG_SEQ_STATS_EN
        chk_eq("stats_tx_count", {16'b0, tx_count}, 32'd12);
        chk_eq("stats_stall_seen", {31'b0, stall_seen}, 32'd1);
`endif

        repeat (30) @(negedge clk_a);
        chk_eq("cdc_all_completed", m_done, n_issued);
        chk_eq("final_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
